mem2axi_master: RTL and testbench
=================================

MEM2AXI_MASTER -- requirements
Module: mem2axi_master

Interface
REQ-001 Parameter ID_WIDTH, default 1: width of all AXI ID ports.
REQ-002 Parameter AXI_ID, default 0: constant driven on o_awid and o_arid.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_req, i_we, i_addr[31:0], i_be[7:0], i_wdata[63:0]  in  local request: valid, write-enable, byte address, byte enables, write data.
REQ-007 o_gnt  out  1  request accepted this cycle.
REQ-008 o_rvalid  out  1  one-cycle completion pulse, for reads and writes.
REQ-009 o_rdata  out  64  read data.
REQ-010 o_err  out  1  completion carried an error response.
REQ-011 AW channel: o_awid[ID_WIDTH], o_awaddr[32], o_awlen[8], o_awsize[3], o_awburst[2], o_awvalid out; i_awready in.
REQ-012 W channel: o_wdata[64], o_wstrb[8], o_wlast, o_wvalid out; i_wready in.
REQ-013 B channel: i_bid[ID_WIDTH], i_bresp[2], i_bvalid in; o_bready out.
REQ-014 AR channel: o_arid, o_araddr[32], o_arlen, o_arsize, o_arburst, o_arvalid out; i_arready in.
REQ-015 R channel: i_rid, i_rdata[64], i_rresp[2], i_rlast, i_rvalid in; o_rready out.

Function
REQ-016 FSM states SHALL be IDLE, WRITE, WRESP, RADDR, RDATA; exactly one transaction outstanding.
REQ-017 o_gnt SHALL equal (state==IDLE) & i_req, combinationally; on that edge i_we/i_addr/i_be/i_wdata are captured into registers.
REQ-018 Accepted write: IDLE->WRITE; o_awvalid and o_wvalid both asserted from the next cycle.
REQ-019 Accepted read: IDLE->RADDR; o_arvalid asserted from the next cycle.
REQ-020 Each valid SHALL stay high, with stable payload, until its own ready handshake, then drop the following cycle.
REQ-021 AW and W handshakes are independent and may occur in either order or the same cycle; WRITE->WRESP once both have completed.
REQ-022 o_bready SHALL be high only in WRESP; on i_bvalid, WRESP->IDLE.
REQ-023 RADDR->RDATA on arvalid&arready; o_rready high only in RDATA; on i_rvalid, RDATA->IDLE.
REQ-024 Address fields SHALL be {addr[31:3],3'b000}.
REQ-025 Length field SHALL be 0; size field 3 (8 bytes); burst field 2'b01 (INCR).
REQ-026 o_wstrb SHALL equal the captured i_be; o_wlast SHALL be 1 whenever o_wvalid is high.
REQ-027 o_rvalid SHALL pulse high for exactly one cycle, the cycle after the B or R handshake.
REQ-028 o_rdata SHALL be loaded from i_rdata on the R handshake and held until the next read completion; writes leave it unchanged.
REQ-029 o_err SHALL equal resp[1] of the completing response, valid with o_rvalid, else 0.
REQ-030 i_bid, i_rid and i_rlast SHALL be ignored.
REQ-031 i_req while not IDLE SHALL be ignored, with o_gnt low; the requester holds it.
REQ-032 Back-to-back: a new request is grantable in the same cycle o_rvalid pulses.

Reset
REQ-033 On rst, the FSM SHALL go to IDLE immediately.
REQ-034 On rst, all valid/ready outputs, o_rvalid, o_err and o_rdata SHALL go to 0 immediately, including mid-transaction.
REQ-035 Outstanding AXI transactions abandoned by reset are not tracked.

Verification
REQ-036 Write i_addr=0x1000_000C, i_be=0xF0, i_wdata=0x1122334455667788, awready/wready always 1 -> awaddr=0x1000_0008, wstrb=0xF0, wlast=1, awlen=0, awsize=3; bresp=0 -> o_rvalid one cycle, o_err=0.
REQ-037 Read 0x2000_0000, arready delayed 3 cycles, rdata=0xDEADBEEFCAFEF00D -> arvalid held 4 cycles with stable araddr; o_rdata=0xDEADBEEFCAFEF00D with o_rvalid.
REQ-038 Write with wready 5 cycles after awready, then reversed order, then same cycle -> one B wait each; no duplicate valids.
REQ-039 Read with rresp=2'b10; write with bresp=2'b11 -> o_err=1 on each completion.
REQ-040 Assert rst while WRESP is waiting -> all outputs 0 immediately, state IDLE; next request granted normally.
REQ-041 Hold i_req continuously for 4 reads -> o_gnt once per transaction; o_gnt never high outside IDLE.

Source files
------------

// File: rtl/mem2axi_if.sv
// AXI4 master-side bus bundle for mem2axi_master: AW, W, B, AR and R channels.
// Ports: master drives o_* valids/payload/readies, slave drives i_* readies/responses.
interface mem2axi_if #(
   parameter int ID_WIDTH = 1
);
   // AW channel
   logic [ID_WIDTH-1:0] o_awid;
   logic [31:0]         o_awaddr;
   logic [7:0]          o_awlen;
   logic [2:0]          o_awsize;
   logic [1:0]          o_awburst;
   logic                o_awvalid;
   logic                i_awready;
   // W channel
   logic [63:0]         o_wdata;
   logic [7:0]          o_wstrb;
   logic                o_wlast;
   logic                o_wvalid;
   logic                i_wready;
   // B channel
   logic [ID_WIDTH-1:0] i_bid;
   logic [1:0]          i_bresp;
   logic                i_bvalid;
   logic                o_bready;
   // AR channel
   logic [ID_WIDTH-1:0] o_arid;
   logic [31:0]         o_araddr;
   logic [7:0]          o_arlen;
   logic [2:0]          o_arsize;
   logic [1:0]          o_arburst;
   logic                o_arvalid;
   logic                i_arready;
   // R channel
   logic [ID_WIDTH-1:0] i_rid;
   logic [63:0]         i_rdata;
   logic [1:0]          i_rresp;
   logic                i_rlast;
   logic                i_rvalid;
   logic                o_rready;

   modport master (
      output o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
      input  i_awready,
      output o_wdata, o_wstrb, o_wlast, o_wvalid,
      input  i_wready,
      input  i_bid, i_bresp, i_bvalid,
      output o_bready,
      output o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
      input  i_arready,
      input  i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
      output o_rready
   );

   modport slave (
      input  o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
      output i_awready,
      input  o_wdata, o_wstrb, o_wlast, o_wvalid,
      output i_wready,
      output i_bid, i_bresp, i_bvalid,
      input  o_bready,
      input  o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
      output i_arready,
      output i_rid, i_rdata, i_rresp, i_rlast, i_rvalid,
      input  o_rready
   );
endinterface

// File: rtl/mem2axi_master.sv
// Bridges a simple single-beat memory request port onto an AXI4 master,
// one transaction outstanding at a time.
// Ports: clk, rst (async, active-high); local request i_req/i_we/i_addr/
// i_be/i_wdata with o_gnt; completion o_rvalid/o_rdata/o_err; axi bus.
module mem2axi_master #(
   parameter int ID_WIDTH = 1,
   parameter int AXI_ID   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [7:0]  i_be,
   input  logic [63:0] i_wdata,
   output logic        o_gnt,
   output logic        o_rvalid,
   output logic [63:0] o_rdata,
   output logic        o_err,
   mem2axi_if.master   axi
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      WRESP,
      RADDR,
      RDATA
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [28:0] addr_q;
   logic [7:0]  be_q;
   logic [63:0] wdata_q;
   logic        aw_done;
   logic        w_done;

   logic        awvalid;
   logic        wvalid;
   logic        bready;
   logic        arvalid;
   logic        rready;

   logic        aw_hs;
   logic        w_hs;
   logic        b_hs;
   logic        ar_hs;
   logic        r_hs;

   // IDs, rlast and the low response/address bits carry no information here.
   logic        unused_sig;
   assign unused_sig = ^{axi.i_bid, axi.i_rid, axi.i_rlast,
                         axi.i_bresp[0], axi.i_rresp[0], i_addr[2:0]};

   assign aw_hs = awvalid & axi.i_awready;
   assign w_hs  = wvalid  & axi.i_wready;
   assign b_hs  = bready  & axi.i_bvalid;
   assign ar_hs = arvalid & axi.i_arready;
   assign r_hs  = rready  & axi.i_rvalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      o_gnt     = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      unique case (state)
         IDLE: begin
            o_gnt = i_req;
            if (i_req) begin
               state_nxt = i_we ? WRITE : RADDR;
            end
         end
         WRITE: begin
            // AW and W complete independently; leave once both are done.
            awvalid = ~aw_done;
            wvalid  = ~w_done;
            if ((aw_done | (~aw_done & axi.i_awready)) &
                (w_done  | (~w_done  & axi.i_wready))) begin
               state_nxt = WRESP;
            end
         end
         WRESP: begin
            bready = 1'b1;
            if (axi.i_bvalid) begin
               state_nxt = IDLE;
            end
         end
         RADDR: begin
            arvalid = 1'b1;
            if (axi.i_arready) begin
               state_nxt = RDATA;
            end
         end
         RDATA: begin
            rready = 1'b1;
            if (axi.i_rvalid) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture on grant; payload stays stable while valids are up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (o_gnt) begin
         addr_q  <= i_addr[31:3];
         be_q    <= i_be;
         wdata_q <= i_wdata;
      end
   end

   // Per-channel completion flags, only meaningful while in WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (state != WRITE) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_done <= 1'b1;
         end
         if (w_hs) begin
            w_done <= 1'b1;
         end
      end
   end

   // Completion pulse lands the cycle after the B or R handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_rvalid <= 1'b0;
         o_err    <= 1'b0;
         o_rdata  <= '0;
      end else begin
         o_rvalid <= b_hs | r_hs;
         o_err    <= (b_hs & axi.i_bresp[1]) | (r_hs & axi.i_rresp[1]);
         if (r_hs) begin
            o_rdata <= axi.i_rdata;
         end
      end
   end

   assign axi.o_awid    = ID_WIDTH'(AXI_ID);
   assign axi.o_awaddr  = {addr_q, 3'b000};
   assign axi.o_awlen   = 8'd0;
   assign axi.o_awsize  = 3'd3;
   assign axi.o_awburst = 2'b01;
   assign axi.o_awvalid = awvalid;

   assign axi.o_wdata   = wdata_q;
   assign axi.o_wstrb   = be_q;
   assign axi.o_wlast   = wvalid;
   assign axi.o_wvalid  = wvalid;

   assign axi.o_bready  = bready;

   assign axi.o_arid    = ID_WIDTH'(AXI_ID);
   assign axi.o_araddr  = {addr_q, 3'b000};
   assign axi.o_arlen   = 8'd0;
   assign axi.o_arsize  = 3'd3;
   assign axi.o_arburst = 2'b01;
   assign axi.o_arvalid = arvalid;

   assign axi.o_rready  = rready;

endmodule

// File: tb/tb_mem2axi_master.sv
// Scoreboard bench for mem2axi_master with a delay-programmable AXI slave.
// Directed stimulus pushes expected completions; a monitor pops on o_rvalid.
module tb_mem2axi_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic        i_we;
   logic [31:0] i_addr;
   logic [7:0]  i_be;
   logic [63:0] i_wdata;
   logic        o_gnt;
   logic        o_rvalid;
   logic [63:0] o_rdata;
   logic        o_err;

   always #5 clk = ~clk;

   mem2axi_if #(.ID_WIDTH(1)) axi ();

   mem2axi_master #(.ID_WIDTH(1), .AXI_ID(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_req    (i_req),
      .i_we     (i_we),
      .i_addr   (i_addr),
      .i_be     (i_be),
      .i_wdata  (i_wdata),
      .o_gnt    (o_gnt),
      .o_rvalid (o_rvalid),
      .o_rdata  (o_rdata),
      .o_err    (o_err),
      .axi      (axi)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] rd;
      logic        err;
   } exp_t;
   exp_t sbq[$];

   // slave configuration
   int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
   logic [1:0]  cfg_bresp = 2'b00;
   logic [1:0]  cfg_rresp = 2'b00;
   logic [63:0] rd_data = '0;
   bit          rd_use_addr = 1'b0;

   // slave observations
   int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
   int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, gnt_cnt = 0;
   int          ar_held = 0;
   bit          ar_unstable = 1'b0;
   logic [31:0] ar_first;
   logic [31:0] cap_awaddr, cap_araddr;
   logic [7:0]  cap_awlen, cap_wstrb;
   logic [2:0]  cap_awsize;
   logic [1:0]  cap_awburst;
   logic        cap_wlast, cap_awid;
   logic [63:0] cap_wdata;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // AXI slave: each ready/valid comes up after its programmed delay.
   initial begin
      axi.i_awready = 0; axi.i_wready = 0; axi.i_arready = 0;
      axi.i_bvalid = 0; axi.i_rvalid = 0; axi.i_bid = 0; axi.i_rid = 0;
      axi.i_bresp = 0; axi.i_rresp = 0; axi.i_rlast = 1; axi.i_rdata = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            axi.i_awready = 0; axi.i_wready = 0; axi.i_arready = 0;
            axi.i_bvalid = 0; axi.i_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
         end else begin
            if (!axi.o_awvalid) begin
               aw_cnt = 0; axi.i_awready = 0;
            end else begin
               axi.i_awready = (aw_cnt >= aw_dly);
               if (axi.i_awready) begin
                  aw_hs++;
                  cap_awaddr = axi.o_awaddr; cap_awlen = axi.o_awlen;
                  cap_awsize = axi.o_awsize; cap_awburst = axi.o_awburst;
                  cap_awid = axi.o_awid;
               end
               aw_cnt++;
            end
            if (!axi.o_wvalid) begin
               w_cnt = 0; axi.i_wready = 0;
            end else begin
               axi.i_wready = (w_cnt >= w_dly);
               if (axi.i_wready) begin
                  w_hs++;
                  cap_wstrb = axi.o_wstrb; cap_wlast = axi.o_wlast;
                  cap_wdata = axi.o_wdata;
               end
               w_cnt++;
            end
            if (!axi.o_arvalid) begin
               ar_cnt = 0; axi.i_arready = 0;
            end else begin
               if (ar_cnt == 0) ar_first = axi.o_araddr;
               else if (axi.o_araddr != ar_first) ar_unstable = 1'b1;
               axi.i_arready = (ar_cnt >= ar_dly);
               ar_cnt++;
               if (axi.i_arready) begin
                  ar_hs++; ar_held = ar_cnt; cap_araddr = axi.o_araddr;
               end
            end
            if (!axi.o_bready) begin
               b_cnt = 0; axi.i_bvalid = 0;
            end else begin
               axi.i_bvalid = (b_cnt >= b_dly);
               axi.i_bresp = cfg_bresp;
               if (axi.i_bvalid) b_hs++;
               b_cnt++;
            end
            if (!axi.o_rready) begin
               r_cnt = 0; axi.i_rvalid = 0;
            end else begin
               axi.i_rvalid = (r_cnt >= r_dly);
               axi.i_rresp = cfg_rresp;
               axi.i_rdata = rd_use_addr ? {cap_araddr, ~cap_araddr} : rd_data;
               r_cnt++;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every completion pulse.
   initial begin
      exp_t e;
      bit   prev_rv;
      prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_rv = 1'b0;
         end else begin
            if (o_rvalid) begin
               chk("rvalid_width", 64'(prev_rv), 64'd0);
               if (sbq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_rvalid: got 1 want 0");
               end else begin
                  e = sbq.pop_front();
                  chk("rdata", o_rdata, e.rd);
                  chk("err", 64'(o_err), 64'(e.err));
               end
            end
            if (o_gnt) begin
               gnt_cnt++;
               chk("gnt_outside_idle",
                   64'({axi.o_awvalid, axi.o_wvalid, axi.o_bready,
                        axi.o_arvalid, axi.o_rready}), 64'd0);
            end
            prev_rv = o_rvalid;
         end
      end
   end

   task automatic wait_gnt(input string name);
      int n = 0;
      #1;
      while (!o_gnt && n < 50) begin
         @(negedge clk); #1; n++;
      end
      chk(name, 64'(o_gnt), 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(negedge clk); n++;
      end
      chk("drain", 64'(sbq.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic issue(input bit we, input logic [31:0] a,
                        input logic [7:0] be, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input bit exp_err);
      exp_t e;
      @(negedge clk);
      i_req = 1; i_we = we; i_addr = a; i_be = be; i_wdata = wd;
      wait_gnt("gnt");
      e.rd = exp_rd; e.err = exp_err;
      sbq.push_back(e);
      @(posedge clk);
      #1 i_req = 0;
      drain();
   endtask

   initial begin
      int a0, w0, b0, g0, r0;
      exp_t e;
      logic [31:0] a;
      rst = 1; i_req = 0; i_we = 0; i_addr = 0; i_be = 0; i_wdata = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_status", 64'({o_gnt, o_rvalid, o_err}), 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      chk("rst_axi", 64'({axi.o_awvalid, axi.o_wvalid, axi.o_bready,
                          axi.o_arvalid, axi.o_rready}), 64'd0);
      @(negedge clk);
      rst = 0;

      // single write, slave always ready
      issue(1, 32'h1000_000C, 8'hF0, 64'h1122334455667788, 64'd0, 0);
      chk("awaddr", 64'(cap_awaddr), 64'h1000_0008);
      chk("wstrb", 64'(cap_wstrb), 64'hF0);
      chk("wlast", 64'(cap_wlast), 64'd1);
      chk("awlen", 64'(cap_awlen), 64'd0);
      chk("awsize", 64'(cap_awsize), 64'd3);
      chk("awburst", 64'(cap_awburst), 64'd1);
      chk("awid", 64'(cap_awid), 64'd0);
      chk("wdata", cap_wdata, 64'h1122334455667788);

      // read with arready held off three cycles
      ar_dly = 3; rd_data = 64'hDEADBEEFCAFEF00D;
      issue(0, 32'h2000_0000, 8'h00, 64'd0, 64'hDEADBEEFCAFEF00D, 0);
      chk("ar_held", 64'(ar_held), 64'd4);
      chk("ar_stable", 64'(ar_unstable), 64'd0);
      chk("araddr", 64'(cap_araddr), 64'h2000_0000);
      ar_dly = 0;

      // W late, AW late, then both together; rdata must be untouched
      for (int k = 0; k < 3; k++) begin
         aw_dly = (k == 1) ? 5 : ((k == 2) ? 2 : 0);
         w_dly  = (k == 0) ? 5 : ((k == 2) ? 2 : 0);
         a0 = aw_hs; w0 = w_hs; b0 = b_hs;
         issue(1, 32'h3000_0010, 8'h0F, 64'h0A0B0C0D0E0F1011,
               64'hDEADBEEFCAFEF00D, 0);
         chk("aw_once", 64'(aw_hs - a0), 64'd1);
         chk("w_once", 64'(w_hs - w0), 64'd1);
         chk("b_once", 64'(b_hs - b0), 64'd1);
      end
      aw_dly = 0; w_dly = 0;

      // error responses
      cfg_rresp = 2'b10; rd_data = 64'h0123456789ABCDEF;
      issue(0, 32'h4000_0008, 8'h00, 64'd0, 64'h0123456789ABCDEF, 1);
      cfg_rresp = 2'b00; cfg_bresp = 2'b11;
      issue(1, 32'h4000_0010, 8'hFF, 64'h5555, 64'h0123456789ABCDEF, 1);
      cfg_bresp = 2'b00;

      // reset while the B response is pending
      b_dly = 20;
      @(negedge clk);
      i_req = 1; i_we = 1; i_addr = 32'h4400_0000; i_be = 8'hFF;
      wait_gnt("gnt_rst");
      @(posedge clk);
      #1 i_req = 0;
      repeat (4) @(negedge clk);
      #1;
      chk("bready_wait", 64'(axi.o_bready), 64'd1);
      #2 rst = 1;
      #1;
      chk("mid_rst_status", 64'({o_gnt, o_rvalid, o_err}), 64'd0);
      chk("mid_rst_rdata", o_rdata, 64'd0);
      chk("mid_rst_axi", 64'({axi.o_awvalid, axi.o_wvalid, axi.o_bready,
                              axi.o_arvalid, axi.o_rready}), 64'd0);
      sbq.delete();
      @(negedge clk);
      rst = 0; b_dly = 0;
      rd_data = 64'hA5A5A5A55A5A5A5A;
      issue(0, 32'h5000_0000, 8'h00, 64'd0, 64'hA5A5A5A55A5A5A5A, 0);

      // four reads with i_req held high throughout
      rd_use_addr = 1;
      g0 = gnt_cnt; r0 = ar_hs;
      @(negedge clk);
      i_req = 1; i_we = 0;
      for (int k = 0; k < 4; k++) begin
         i_addr = 32'h6000_0005 + 32'(k * 8);
         if (k == 0) wait_gnt("gnt_hold");
         else begin
            @(negedge clk);
            wait_gnt("gnt_hold");
            chk("b2b_rvalid", 64'(o_rvalid), 64'd1);
         end
         a = i_addr & 32'hFFFF_FFF8;
         e.rd = {a, ~a}; e.err = 0;
         sbq.push_back(e);
         @(posedge clk);
         #1;
      end
      i_req = 0;
      drain();
      chk("hold_gnts", 64'(gnt_cnt - g0), 64'd4);
      chk("hold_ars", 64'(ar_hs - r0), 64'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
